// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, receiver FSM states, channel codes.
// Pure declarations; no latency or flow control involved.
package audio_pkg;
  localparam int AUDIO_DW = 16;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, DONE} rx_state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
endpackage

// File: rtl/i2s_adc_rx_if.sv
// I2S ADC pins plus the stereo sample / error outputs of the receiver.
// slave = receiver side, master = CODEC/consumer side.
interface i2s_adc_rx_if
  import audio_pkg::*;
#(
  parameter int DW = AUDIO_DW
);
  logic          aud_bclk;
  logic          aud_adclrck;
  logic          aud_adcdat;
  logic          err_clr;
  logic [DW-1:0] ldata;
  logic [DW-1:0] rdata;
  logic          sample_valid;
  logic          frame_err;

  modport slave (
    input  aud_bclk, aud_adclrck, aud_adcdat, err_clr,
    output ldata, rdata, sample_valid, frame_err
  );

  modport master (
    output aud_bclk, aud_adclrck, aud_adcdat, err_clr,
    input  ldata, rdata, sample_valid, frame_err
  );
endinterface

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser with registered rising-edge detect; dout is delayed to align with rise.
// Latency: pin to dout/rise = SYNC_STAGES+1 clk; no backpressure.
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign dout = prev_q;
  assign rise = rise_q;
endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC deserialiser to stereo samples; define I2S_RX_LJ_EN for left-justified (no delay slot).
// Latency: final right bit's bclk rise -> sample_valid 1 clk; no backpressure, strobe only.
module i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int DW          = AUDIO_DW,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  i2s_adc_rx_if.slave aud
);
  localparam int CW = $clog2(DW + 1);

  logic bclk_rise, lrck_s, dat_s, bclk_unused, lrck_rise_unused, dat_rise_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
    .clk(clk), .rst(rst), .din(aud.aud_bclk), .dout(bclk_unused), .rise(bclk_rise));
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (
    .clk(clk), .rst(rst), .din(aud.aud_adclrck), .dout(lrck_s), .rise(lrck_rise_unused));
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dat (
    .clk(clk), .rst(rst), .din(aud.aud_adcdat), .dout(dat_s), .rise(dat_rise_unused));

  rx_state_e     state_q, state_d;
  logic          chan_q, chan_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shreg_q, shreg_d, hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DW-1:0] ldata_q, ldata_d, rdata_q, rdata_d;
  logic          have_l_q, have_l_d, lrck_prev_q, lrck_prev_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          lrck_edge, err_set;
  logic [DW-1:0] word_new;

  assign lrck_edge = bclk_rise & (lrck_s != lrck_prev_q);
  assign word_new  = {shreg_q[DW-2:0], dat_s};

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    ldata_d     = ldata_q;
    rdata_d     = rdata_q;
    have_l_d    = have_l_q;
    lrck_prev_d = lrck_prev_q;
    valid_d     = 1'b0;
    err_set     = 1'b0;

    if (bclk_rise) begin
      lrck_prev_d = lrck_s;
      shreg_d     = word_new;
      if (lrck_edge) begin
        // A word select change mid-word means the partial word is unusable.
        if (state_q == SHIFT) begin
          err_set  = 1'b1;
          have_l_d = 1'b0;
        end
        chan_d = lrck_s;
`ifdef I2S_RX_LJ_EN
        state_d = SHIFT;
        cnt_d   = CW'(1);
`else
        state_d = DELAY;
        cnt_d   = '0;
`endif
      end else begin
        case (state_q)
          DELAY: begin
            state_d = SHIFT;
            cnt_d   = CW'(1);
          end
          SHIFT: begin
            if (cnt_q == CW'(DW - 1)) begin
              cnt_d   = CW'(DW);
              state_d = DONE;
              if (chan_q == CH_LEFT) begin
                hold_l_d = word_new;
                have_l_d = 1'b1;
              end else begin
                hold_r_d = word_new;
                if (have_l_q) begin
                  ldata_d  = hold_l_q;
                  rdata_d  = word_new;
                  valid_d  = 1'b1;
                  have_l_d = 1'b0;
                end else begin
                  err_set = 1'b1;
                end
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end

    if (err_set)          err_d = 1'b1;
    else if (aud.err_clr) err_d = 1'b0;
    else                  err_d = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      chan_q      <= CH_LEFT;
      cnt_q       <= '0;
      shreg_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      ldata_q     <= '0;
      rdata_q     <= '0;
      have_l_q    <= 1'b0;
      lrck_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      ldata_q     <= ldata_d;
      rdata_q     <= rdata_d;
      have_l_q    <= have_l_d;
      lrck_prev_q <= lrck_prev_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign aud.ldata        = ldata_q;
  assign aud.rdata        = rdata_q;
  assign aud.sample_valid = valid_q;
  assign aud.frame_err    = err_q;
endmodule

// File: tb/tb_i2s_adc_rx.sv
// Scoreboard bench for i2s_adc_rx: BCLK = clk/8, 32-bit slots, expected samples queued at drive time.
module tb_i2s_adc_rx;
`ifdef I2S_RX_LJ_EN
  localparam int OFF = 0;
`else
  localparam int OFF = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2s_adc_rx_if #(.DW(16)) aud ();
  i2s_adc_rx #(.DW(16), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .aud(aud));

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_strobes = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          strobe_cyc[$];
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every strobe must match the oldest queued expectation and last one cycle.
  initial begin
    logic        prev_v;
    logic [31:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (aud.sample_valid === 1'b1) begin
        n_strobes++;
        strobe_cyc.push_back(cyc);
        if (prev_v) check("strobe_width", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ldata", {16'h0, aud.ldata}, {16'h0, e[31:16]});
          check("rdata", {16'h0, aud.rdata}, {16'h0, e[15:0]});
        end
      end
      prev_v = aud.sample_valid;
    end
  end

  function automatic logic [15:0] extract(input logic [31:0] pat);
    return pat[31-OFF -: 16];
  endfunction

  function automatic logic [31:0] i2s(input logic [15:0] w);
    return {1'b0, w, 15'h0};
  endfunction

  task automatic send_bit(input logic ch, input logic b);
    @(posedge clk);
    #1;
    aud.aud_bclk    = 1'b0;
    aud.aud_adclrck = ch;
    aud.aud_adcdat  = b;
    repeat (4) @(posedge clk);
    #1 aud.aud_bclk = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_slot(input logic ch, input logic [31:0] pat, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(ch, pat[31-i]);
  endtask

  task automatic send_frame(input logic [31:0] lpat, input logic [31:0] rpat, input logic expect_strobe);
    send_slot(1'b0, lpat, 32);
    if (expect_strobe) exp_q.push_back({extract(lpat), extract(rpat)});
    send_slot(1'b1, rpat, 32);
  endtask

  // One right-channel bit so the following left slot starts on a genuine word-select edge.
  task automatic lead_in();
    send_bit(1'b1, 1'b0);
`ifdef I2S_RX_LJ_EN
    exp_err = 1'b1;
`endif
  endtask

  task automatic clear_err();
    @(posedge clk);
    #1 aud.err_clr = 1'b1;
    @(posedge clk);
    #1 aud.err_clr = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    check({tag, "_ldata"}, {16'h0, aud.ldata}, 32'h0);
    check({tag, "_rdata"}, {16'h0, aud.rdata}, 32'h0);
    check({tag, "_valid"}, {31'h0, aud.sample_valid}, 32'h0);
    check({tag, "_err"}, {31'h0, aud.frame_err}, 32'h0);
  endtask

  initial begin
    int base;
    rst             = 1'b1;
    aud.aud_bclk    = 1'b0;
    aud.aud_adclrck = 1'b0;
    aud.aud_adcdat  = 1'b0;
    aud.err_clr     = 1'b0;
    repeat (5) @(posedge clk);
    check_reset("rst0");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single frame after reset
    lead_in();
    send_frame(i2s(16'h1234), i2s(16'hABCD), 1'b1);
    repeat (4) @(posedge clk);
    check("t1_strobes", n_strobes, 1);
    check("t1_err", {31'h0, aud.frame_err}, {31'h0, exp_err});
    if (exp_err) clear_err();

    // Ten back-to-back frames, one frame (64 bits * 8 clk) apart
    base = n_strobes;
    strobe_cyc.delete();
    for (int n = 1; n <= 10; n++) send_frame(i2s(16'(n)), i2s(~16'(n)), 1'b1);
    repeat (4) @(posedge clk);
    check("b2b_strobes", n_strobes - base, 10);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check("b2b_spacing", strobe_cyc[i] - strobe_cyc[i-1], 512);
    check("b2b_err", {31'h0, aud.frame_err}, 32'h0);

    // Short left word: LRCK toggles after 10 data bits
    base = n_strobes;
    send_slot(1'b0, i2s(16'h1234), 1 + 10);
    send_slot(1'b1, i2s(16'h4321), 32);
    @(negedge clk);
    check("short_err", {31'h0, aud.frame_err}, 32'h1);
    check("short_nostrobe", n_strobes - base, 0);
    send_frame(i2s(16'h0F0F), i2s(16'hF0F0), 1'b1);
    @(negedge clk);
    check("short_sticky", {31'h0, aud.frame_err}, 32'h1);
    clear_err();
    @(negedge clk);
    check("short_errclr", {31'h0, aud.frame_err}, 32'h0);

    // Reset mid right word after a valid left word
    send_slot(1'b0, i2s(16'h1111), 32);
    send_slot(1'b1, i2s(16'h2222), 8);
    @(posedge clk);
    #1 aud.aud_bclk = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check_reset("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    base = n_strobes;
    lead_in();
    send_frame(i2s(16'h5555), i2s(16'hAAAA), 1'b1);
    repeat (4) @(posedge clk);
    check("midrst_strobes", n_strobes - base, 1);
    check("midrst_err", {31'h0, aud.frame_err}, {31'h0, exp_err});
    if (exp_err) clear_err();

    // 24-bit slot data: only the top 16 bits are kept
    send_frame({1'b0, 24'h123456, 7'h0}, {1'b0, 24'h789ABC, 7'h0}, 1'b1);
    repeat (4) @(posedge clk);
    check("w24_err", {31'h0, aud.frame_err}, 32'h0);

    // Left-justified stream: MSB on the word-select edge bit
    send_frame({16'h8001, 16'h0}, {16'h7FFE, 16'h0}, 1'b1);
    repeat (50) @(posedge clk);
    check("lj_err", {31'h0, aud.frame_err}, 32'h0);

    check("sb_empty", exp_q.size(), 0);
    check("strobe_total", n_strobes, 15);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
